// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the byte-enable true-dual-port RAM:
// same-port write-mode selector and the init-sweep FSM encoding.
package tdp_ram_pkg;

   typedef enum logic [1:0] {
      WM_READ_FIRST  = 2'd0,
      WM_WRITE_FIRST = 2'd1,
      WM_NO_CHANGE   = 2'd2
   } wr_mode_e;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

endpackage

// File: rtl/tdp_ram_be_if.sv
// One RAM port: request strobe, byte enables, address, write data,
// plus the returned read data and its valid pulse.
interface tdp_ram_be_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
);
   localparam int NUM_BYTES = DATA_WIDTH / 8;

   logic                  en;
   logic [NUM_BYTES-1:0]  be;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  valid;

   modport master (output en, be, addr, wdata, input  rdata, valid);
   modport slave  (input  en, be, addr, wdata, output rdata, valid);

endinterface

// File: rtl/ram_out_pipe.sv
// Per-port read-data/valid register chain of READ_LATENCY stages; the data
// of each stage only advances with a valid token, so the output holds.
module ram_out_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [READ_LATENCY-1:0] vld_q;
   logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples the value its predecessor held before this edge.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
      end else begin
         vld_q[0] <= in_valid;
         if (in_valid) dat_q[0] <= in_data;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[READ_LATENCY-1];
   assign out_data  = dat_q[READ_LATENCY-1];

endmodule

// File: rtl/tdp_ram_be.sv
// True-dual-port RAM with byte enables, optional zero-fill sweep after reset,
// selectable same-port write mode and a same-address collision flag.
module tdp_ram_be
   import tdp_ram_pkg::*;
#(
   parameter int       DATA_WIDTH    = 32,
   parameter int       ADDR_WIDTH    = 10,
   parameter int       READ_LATENCY  = 1,
   parameter wr_mode_e WRITE_MODE    = WM_READ_FIRST,
   parameter bit       INIT_ON_RESET = 1'b1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   tdp_ram_be_if.slave port_a,
   tdp_ram_be_if.slave port_b,
   output logic        init_busy_o,
   output logic        collision_o
);

   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   typedef logic [NUM_BYTES-1:0][7:0] word_t;

   function automatic word_t merge_word(input word_t                 old_w,
                                        input logic [NUM_BYTES-1:0]  be,
                                        input logic [DATA_WIDTH-1:0] wdata);
      word_t res;
      res = old_w;
      for (int k = 0; k < NUM_BYTES; k++)
         if (be[k]) res[k] = wdata[8*k +: 8];
      return res;
   endfunction

   word_t                 mem [DEPTH];
   state_e                state;
   logic [ADDR_WIDTH-1:0] init_cnt;
   logic                  init_busy_q;
   logic                  collision_q;

   // ---------------- init sweep FSM ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state       <= INIT_ON_RESET ? ST_INIT : ST_READY;
         init_busy_q <= INIT_ON_RESET;
         init_cnt    <= '0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (&init_cnt) begin
                  state       <= ST_READY;
                  init_busy_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- request qualification ----------------
   logic acc_a, acc_b, wr_a, wr_b, init_wr;

   assign init_wr = (state == ST_INIT)  && !reset_i;
   assign acc_a   = (state == ST_READY) && !reset_i && port_a.en;
   assign acc_b   = (state == ST_READY) && !reset_i && port_b.en;
   assign wr_a    = acc_a && (|port_a.be);
   assign wr_b    = acc_b && (|port_b.be);

   // ---------------- array ----------------
   // NOTE: the storage array has no reset; clearing is done by the sweep,
   // which keeps the array mappable to block RAM.
   always_ff @(posedge clk_i) begin
      if (init_wr) mem[init_cnt] <= '0;
      for (int k = 0; k < NUM_BYTES; k++)
         if (wr_b && port_b.be[k]) mem[port_b.addr][k] <= port_b.wdata[8*k +: 8];
      // Port A lanes are assigned last so they win on overlapping writes.
      for (int k = 0; k < NUM_BYTES; k++)
         if (wr_a && port_a.be[k]) mem[port_a.addr][k] <= port_a.wdata[8*k +: 8];
   end

   // ---------------- read path ----------------
   word_t                 rd_a, rd_b;
   logic [DATA_WIDTH-1:0] pipe_d_a, pipe_d_b;
   logic                  pipe_v_a, pipe_v_b;

   // NOTE: every always_comb output gets a value on every path, so no
   // latch is inferred.
   always_comb begin
      rd_a     = mem[port_a.addr];
      rd_b     = mem[port_b.addr];
      pipe_d_a = rd_a;
      pipe_d_b = rd_b;
      if (WRITE_MODE == WM_WRITE_FIRST && wr_a)
         pipe_d_a = merge_word(rd_a, port_a.be, port_a.wdata);
      if (WRITE_MODE == WM_WRITE_FIRST && wr_b)
         pipe_d_b = merge_word(rd_b, port_b.be, port_b.wdata);
      pipe_v_a = acc_a && !(WRITE_MODE == WM_NO_CHANGE && wr_a);
      pipe_v_b = acc_b && !(WRITE_MODE == WM_NO_CHANGE && wr_b);
   end

   ram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_a (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .in_valid  (pipe_v_a),
      .in_data   (pipe_d_a),
      .out_valid (port_a.valid),
      .out_data  (port_a.rdata)
   );

   ram_out_pipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_pipe_b (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .in_valid  (pipe_v_b),
      .in_data   (pipe_d_b),
      .out_valid (port_b.valid),
      .out_data  (port_b.rdata)
   );

   // Collision flag is one register deep regardless of READ_LATENCY.
   always_ff @(posedge clk_i) begin
      if (reset_i) collision_q <= 1'b0;
      else         collision_q <= acc_a && acc_b && (port_a.addr == port_b.addr)
                                  && (wr_a || wr_b);
   end

   assign init_busy_o = init_busy_q;
   assign collision_o = collision_q;

endmodule
